// File: rtl/par_to_serial_if.sv
// Parallel-in lane handshake and serial-out status bundle for par_to_serial.
interface par_to_serial_if;
  logic [7:0] data_in;
  logic       valid_in;
  logic       load;
  logic       data_out;
  logic       active;

  modport master (output data_in, output valid_in,
                  input  load,    input  data_out, input active);
  modport slave  (input  data_in, input  valid_in,
                  output load,    output data_out, output active);
endinterface

// File: rtl/par_to_serial.sv
// Byte-to-serial converter, MSB first. Sends a COM_CHAR sync preamble after
// reset, then one byte per 8 clocks, filling idle slots with COM_CHAR.
module par_to_serial #(
  parameter logic [7:0] COM_CHAR   = 8'hBC,
  parameter int         SYNC_BYTES = 4
) (
  input  logic           clk,
  input  logic           reset,
  par_to_serial_if.slave bus
);

  typedef enum logic {SYNC, ACTIVE} state_t;

  localparam logic [3:0] SYNC_LAST = 4'(SYNC_BYTES - 1);

  logic [7:0] shreg_q, shreg_d;
  logic [2:0] cnt_q, cnt_d;
  logic [3:0] sync_q, sync_d;
  state_t     state_q, state_d;
  logic [7:0] next_byte;
  logic       byte_edge;

  assign byte_edge = (cnt_q == 3'd7);
  assign bus.load  = byte_edge && (state_q == ACTIVE);

  // Upstream data only matters on a load edge; SYNC and idle slots send COM_CHAR.
  assign next_byte = (bus.load && bus.valid_in) ? bus.data_in : COM_CHAR;

  always_comb begin
    shreg_d = {shreg_q[6:0], 1'b0};
    cnt_d   = cnt_q + 3'd1;
    sync_d  = sync_q;
    state_d = state_q;
    if (byte_edge) begin
      shreg_d = next_byte;
      cnt_d   = 3'd0;
      if (state_q == SYNC) begin
        sync_d = sync_q + 4'd1;
        if (sync_q == SYNC_LAST) state_d = ACTIVE;
      end
    end
  end

  // cnt resets to 7 so the very first edge after release loads COM_CHAR #1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg_q <= 8'h00;
      cnt_q   <= 3'd7;
      sync_q  <= 4'd0;
      state_q <= SYNC;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      sync_q  <= sync_d;
      state_q <= state_d;
    end
  end

  assign bus.data_out = shreg_q[7];
  assign bus.active   = (state_q == ACTIVE);

endmodule
